// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts it out
// LSB-first framed by one start bit and one stop bit, CLKS_PER_BIT clocks per bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx,
    output logic       o_tx_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            o_tx       <= 1'b1;
            o_tx_ready <= 1'b0;
            o_tx_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_tx   <= 1'b1;
                    r_baud <= '0;
                    // ready comes up one edge after reset, so no byte is taken on that edge
                    if (!o_tx_ready) begin
                        o_tx_ready <= 1'b1;
                    end else if (i_tx_valid) begin
                        r_shift    <= i_tx_data;
                        r_bit      <= '0;
                        o_tx       <= 1'b0;
                        o_tx_ready <= 1'b0;
                        o_tx_busy  <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        o_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            o_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            o_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud     <= '0;
                        o_tx_ready <= 1'b1;
                        o_tx_busy  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (4 and 2 clocks/bit) checked every cycle against a
// frame-position model, plus a line-sampling receiver that decodes every completed frame.
module tb_uart_tx;

    localparam int C0   = 4;
    localparam int C1   = 2;
    localparam int LOGN = 4096;
    localparam int MAXF = 128;
    localparam int CP [2] = '{C0, C1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [1:0] valid = 2'b00;
    logic [1:0] ready, tx, busy;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data0), .i_tx_valid(valid[0]),
        .o_tx_ready(ready[0]), .o_tx(tx[0]), .o_tx_busy(busy[0]));

    uart_tx #(.CLKS_PER_BIT(C1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data1), .i_tx_valid(valid[1]),
        .o_tx_ready(ready[1]), .o_tx(tx[1]), .o_tx_busy(busy[1]));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // model: position within the current frame, counted in clocks from the handshake edge
    bit         m_ready [2];
    bit         m_busy  [2];
    bit         m_act   [2];
    bit         m_tx    [2];
    bit         hs_now  [2];
    int         m_pos   [2];
    logic [7:0] m_byte  [2];

    logic       lg       [2][LOGN];
    int         fr_cyc   [2][MAXF];
    logic [7:0] fr_byte  [2][MAXF];
    bit         fr_abort [2][MAXF];
    int         nfr      [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit line_bit(input int ch);
        int b;
        b = m_pos[ch] / CP[ch];
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_byte[ch][b-1];
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_ready[ch] = 0; m_busy[ch] = 0; m_act[ch] = 0; m_tx[ch] = 1; hs_now[ch] = 0;
            for (int f = 0; f < nfr[ch]; f++)
                if (fr_cyc[ch][f] + 10 * CP[ch] >= cyc) fr_abort[ch][f] = 1;
        end
    endtask

    task automatic model_edge(input int ch, input bit v, input logic [7:0] d);
        hs_now[ch] = v && m_ready[ch];
        if (hs_now[ch]) begin
            m_act[ch] = 1; m_pos[ch] = 0; m_byte[ch] = d; m_ready[ch] = 0; m_busy[ch] = 1;
            if (nfr[ch] < MAXF) begin
                fr_cyc[ch][nfr[ch]] = cyc; fr_byte[ch][nfr[ch]] = d; fr_abort[ch][nfr[ch]] = 0;
                nfr[ch]++;
            end
        end else if (m_act[ch]) begin
            m_pos[ch]++;
            if (m_pos[ch] == 10 * CP[ch]) begin
                m_act[ch] = 0; m_ready[ch] = 1; m_busy[ch] = 0;
            end
        end else begin
            m_ready[ch] = 1; m_busy[ch] = 0;
        end
        m_tx[ch] = m_act[ch] ? line_bit(ch) : 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_edge(0, valid[0], data0);
            model_edge(1, valid[1], data1);
        end else begin
            hs_now[0] = 0; hs_now[1] = 0;
        end
        @(negedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            chk($sformatf("tx%0d@%0d", ch, cyc), 32'(tx[ch]), 32'(m_tx[ch]));
            chk($sformatf("rdy%0d@%0d", ch, cyc), 32'(ready[ch]), 32'(m_ready[ch]));
            chk($sformatf("bsy%0d@%0d", ch, cyc), 32'(busy[ch]), 32'(m_busy[ch]));
            if (cyc < LOGN) lg[ch][cyc] = tx[ch];
        end
        cyc++;
        valid[1] = ($urandom_range(0, 3) != 0);
        data1 = (nfr[1] == 0) ? 8'h01 : 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send0(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        data0 = b;
        valid[0] = 1'b1;
        step();
        while (!hs_now[0] && n < 200) begin
            step();
            n++;
        end
        chk("hs_seen", 32'(hs_now[0]), 32'd1);
        if (!hold) valid[0] = 1'b0;
    endtask

    function automatic int find_fall(input int ch, input int from);
        for (int i = (from < 1 ? 1 : from); i < cyc && i < LOGN; i++)
            if (lg[ch][i-1] == 1'b1 && lg[ch][i] == 1'b0) return i;
        return -1;
    endfunction

    initial begin
        int rel, k1, f1, f2, run;
        logic [7:0] rx;
        nfr[0] = 0; nfr[1] = 0;
        model_reset();

        // reset held 3 cycles with valid high on the C=4 channel
        data0 = 8'hA5;
        valid[0] = 1'b1;
        idle(3);
        rst = 1'b0;
        rel = cyc;
        send0(8'hA5, 0);
        chk("first_hs_edge", 32'(fr_cyc[0][0] - rel), 32'd1);
        idle(44);

        // data change right after acceptance must not reach the line
        send0(8'h3C, 0);
        data0 = 8'hFF;
        idle(44);

        // back-to-back with valid held
        send0(8'h00, 1);
        k1 = fr_cyc[0][nfr[0]-1];
        send0(8'hFF, 0);
        idle(44);
        f1 = find_fall(0, k1);
        f2 = (f1 >= 0) ? find_fall(0, f1 + 1) : -1;
        chk("b2b_gap", 32'(f2 - f1), 32'(10 * C0 + 1));
        run = 0;
        if (f2 > 0)
            for (int i = f2 - 1; i >= 0 && lg[0][i] == 1'b1; i--) run++;
        chk("b2b_stop_len", 32'(run), 32'(C0 + 1));

        // reset during data bit 3 of 0x55 (a low bit)
        send0(8'h55, 0);
        idle(4 * C0);
        rst = 1'b1;
        #1;
        chk("async_tx", 32'(tx[0]), 32'd1);
        chk("async_rdy", 32'(ready[0]), 32'd0);
        chk("async_bsy", 32'(busy[0]), 32'd0);
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(3);
        send0(8'h81, 0);
        idle(44);

        // random bytes, gaps and hold patterns
        for (int r = 0; r < 6; r++) begin
            idle($urandom_range(0, 6));
            send0(8'($urandom), 1'($urandom_range(0, 1)));
        end
        valid[0] = 1'b0;
        idle(50);

        // receiver: sample mid-bit on every completed, non-aborted frame
        for (int ch = 0; ch < 2; ch++) begin
            for (int f = 0; f < nfr[ch]; f++) begin
                int k;
                k = fr_cyc[ch][f];
                if (!fr_abort[ch][f] && k + 10 * CP[ch] < cyc && k + 10 * CP[ch] < LOGN) begin
                    for (int i = 0; i < 8; i++) rx[i] = lg[ch][k + CP[ch] * (1 + i) + CP[ch] / 2];
                    chk($sformatf("rx_start%0d_%0d", ch, f), 32'(lg[ch][k + CP[ch] / 2]), 32'd0);
                    chk($sformatf("rx_byte%0d_%0d", ch, f), 32'(rx), 32'(fr_byte[ch][f]));
                    chk($sformatf("rx_stop%0d_%0d", ch, f), 32'(lg[ch][k + 9 * CP[ch] + CP[ch] / 2]), 32'd1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
